sig_check: RTL and testbench
============================

# sig_check

Receive-side checker for the CRC-driven self-check stream. An upstream transmitter emits a 64-bit LFSR sequence. The DUT returns `crc[31:0] + OFFSET` on each beat. This block regenerates the same LFSR locally and compares every received beat against its prediction. It also folds the received beats into a 64-bit MISR signature and reports pass/fail once the stream ends. It sits at the output of the parameterized DUT in a regression top, replacing ad-hoc `$stop` checks with a synthesizable verdict.

## Interface
- `SEED`, 64'h5aef0c8d_d70a4497, initial local LFSR value (beat 0 prediction source)
- `OFFSET`, 32'd2, constant the DUT adds to `crc[31:0]`
- `WARMUP`, 10, number of leading beats excluded from the signature
- `LAST`, 99, index of the final beat; the verdict is taken when it is accepted
- `EXPECTED_SUM`, 64'hf9b3a5000165ed38, golden MISR value
- `clk  in  1  sole clock, all logic on posedge`
- `reset_l  in  1  synchronous, active-low reset`
- `in_valid  in  1  beat strobe from DUT; one beat per cycle when high`
- `in_data  in  32  DUT output for the current beat`
- `beat  out  32  count of accepted beats`
- `sum  out  64  current MISR signature`
- `err_count  out  16  mismatching beats, saturating at 16'hffff`
- `done  out  1  high once the verdict is valid; sticky`
- `pass  out  1  verdict; meaningful only while done=1`

## Operation
- **Reset** (`reset_l`=0 at a clock edge) sets:
  - `crc`=SEED
  - `sum`, `beat`, `err_count`, `done`, `pass` = 0
  - state = S_IDLE
- **LFSR step:** `crc_n = {crc[62:0], crc[63]^crc[2]^crc[0]}`.
- **MISR step:** `sum_n = {32'h0, in_data} ^ {sum[62:0], sum[63]^sum[2]^sum[0]}`.
- **Prediction:** `exp = crc[31:0] + OFFSET`, truncated mod 2^32, with no carry out.
- **Accepted beat:** `in_valid`=1 in any state except S_DONE.
- **On each accepted beat:**
  - compare `in_data` to `exp` on every beat, warmup included; on mismatch increment `err_count`, saturating
  - advance `crc` by one step
  - increment `beat`
- **States:**
  - S_IDLE: no beat accepted yet. The first accepted beat moves to S_WARM, or to S_ACCUM if WARMUP=0.
  - S_WARM: `sum` is held at 0. When the beat with index WARMUP-1 is accepted, move to S_ACCUM.
  - S_ACCUM: `sum` <= `sum_n` on each accepted beat with index < LAST. When beat LAST is accepted, it is compared but not folded in, and the state moves to S_DONE.
  - S_DONE: ignores `in_valid`; all counters frozen; `done`=1; `pass = (sum==EXPECTED_SUM) && (err_count==0)`. Held until reset.
- **Gaps:** `in_valid`=0 cycles freeze all state. The verdict depends only on the beat sequence, not on timing.
- **Simultaneous events:** `reset_l`=0 wins over `in_valid` in the same cycle.

## Timing
- Registered outputs; no combinational path from inputs to outputs.
- Compare latency is 1 cycle: `err_count` reflects beat k in the cycle after its acceptance.
- `done` and `pass` rise together, 1 cycle after beat LAST is accepted.
- Reset mid-stream: outputs read reset values in the cycle after the reset edge. The next accepted beat is treated as beat 0 and is predicted from SEED.
- No backpressure: `in_valid` is never stalled, and the block has no ready output.
- `beat` never wraps in practice, because LAST < 2^32.

## Structure
- Package `sig_check_pkg` holds:
  - state enum (S_IDLE, S_WARM, S_ACCUM, S_DONE)
  - tap positions {63,2,0}
  - default SEED and EXPECTED_SUM constants
- Sub-module `lfsr_step`: combinational 64-bit shift with the tap XOR. It is instantiated twice, once for `crc` and once for the MISR feedback term, with the MISR instance adding the `in_data` XOR.
- The top level holds the FSM, counters, comparator and verdict register.

## Test plan
- Clean stream, 100 contiguous beats; the bench transmitter model uses SEED and OFFSET=2, so beat 0 is 0xd70a4499 -> `done`=1 one cycle after beat 99, `pass`=1, `err_count`=0, `sum`=0xf9b3a5000165ed38.
- Same stream with bit 0 of beat 50 flipped -> `err_count`=1, `sum`≠EXPECTED_SUM, `pass`=0.
- Bit flip on beat 3 (warmup) -> `err_count`=1, `sum` still equals EXPECTED_SUM, `pass`=0.
- Same clean stream with random 0–3 cycle `in_valid` gaps -> final `sum`, `err_count` and `pass` are identical to the contiguous run.
- `reset_l` pulsed low after beat 40, then a full clean stream -> `beat`=0 the cycle after reset, final `pass`=1.
- OFFSET=32'hffffffff -> beat 0 expects 0xd70a4496 (wrap); a matching stream gives `err_count`=0. Beats sent after `done` are ignored, with `beat` staying at 100.

Source files
------------

// File: rtl/sig_check_pkg.sv
// Shared types and constants for the LFSR self-check receiver.
package sig_check_pkg;

   localparam int unsigned LFSR_W = 64;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ERR_W  = 16;
   localparam int unsigned BEAT_W = 32;

   // Feedback taps of the x^64 + x^3 + x^1 style shift register.
   localparam int unsigned TAP_HI  = 63;
   localparam int unsigned TAP_MID = 2;
   localparam int unsigned TAP_LO  = 0;

   localparam logic [LFSR_W-1:0] DEF_SEED         = 64'h5aef0c8d_d70a4497;
   localparam logic [LFSR_W-1:0] DEF_EXPECTED_SUM = 64'hf9b3a500_0165ed38;
   localparam logic [DATA_W-1:0] DEF_OFFSET       = 32'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WARM  = 2'd1,
      S_ACCUM = 2'd2,
      S_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/sig_check_lfsr_step.sv
// One combinational LFSR advance with an optional injected term (MISR use).
module lfsr_step
   import sig_check_pkg::*;
(
   input  logic [LFSR_W-1:0] state_i,
   input  logic [LFSR_W-1:0] inject_i,
   output logic [LFSR_W-1:0] next_c_o
);

   // Shift left, feed back the tap XOR into bit 0, then fold in the injected word.
   assign next_c_o = {state_i[LFSR_W-2:0],
                      state_i[TAP_HI] ^ state_i[TAP_MID] ^ state_i[TAP_LO]} ^ inject_i;

endmodule

// File: rtl/sig_check.sv
// Receive-side checker: predicts each beat from a local LFSR, counts
// mismatches, folds beats into a MISR signature and latches a verdict.
module sig_check
   import sig_check_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED         = DEF_SEED,
   parameter logic [DATA_W-1:0] OFFSET       = DEF_OFFSET,
   parameter int unsigned       WARMUP       = 10,
   parameter int unsigned       LAST         = 99,
   parameter logic [LFSR_W-1:0] EXPECTED_SUM = DEF_EXPECTED_SUM
)(
   input  logic              clk,
   input  logic              reset_l,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic [BEAT_W-1:0] beat,
   output logic [LFSR_W-1:0] sum,
   output logic [ERR_W-1:0]  err_count,
   output logic              done,
   output logic              pass
);

   state_e              state_q, state_d;
   logic [LFSR_W-1:0]   crc_q, crc_d;
   logic [LFSR_W-1:0]   sum_q, sum_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;

   logic [LFSR_W-1:0]   crc_step_c;
   logic [LFSR_W-1:0]   misr_step_c;
   logic [DATA_W-1:0]   exp_c;
   logic                accept_c;
   logic                mismatch_c;
   logic                is_last_c;
   logic                warm_end_c;
   logic                fold_c;

   lfsr_step u_crc_step (
      .state_i  (crc_q),
      .inject_i (LFSR_W'(0)),
      .next_c_o (crc_step_c)
   );

   lfsr_step u_misr_step (
      .state_i  (sum_q),
      .inject_i ({{(LFSR_W-DATA_W){1'b0}}, in_data}),
      .next_c_o (misr_step_c)
   );

   // Beat qualification and prediction compare.
   always_comb begin
      exp_c      = crc_q[DATA_W-1:0] + OFFSET;
      accept_c   = in_valid && (state_q != S_DONE);
      mismatch_c = (in_data != exp_c);
      is_last_c  = (beat_q == BEAT_W'(LAST));
      warm_end_c = ((beat_q + BEAT_W'(1)) >= BEAT_W'(WARMUP));
      fold_c     = ((state_q == S_ACCUM) || ((state_q == S_IDLE) && (WARMUP == 0)))
                   && !is_last_c;
   end

   // Next-state logic: FSM, counters, signature and verdict.
   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      sum_d   = sum_q;
      beat_d  = beat_q;
      err_d   = err_q;
      done_d  = done_q;
      pass_d  = pass_q;

      if (accept_c) begin
         crc_d  = crc_step_c;
         beat_d = beat_q + BEAT_W'(1);
         if (mismatch_c && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
         end
         if (fold_c) begin
            sum_d = misr_step_c;
         end

         case (state_q)
            S_IDLE, S_WARM, S_ACCUM: begin
               if (is_last_c) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = (sum_q == EXPECTED_SUM) && (err_d == '0);
               end else if (warm_end_c) begin
                  state_d = S_ACCUM;
               end else begin
                  state_d = S_WARM;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state_q <= S_IDLE;
         crc_q   <= SEED;
         sum_q   <= '0;
         beat_q  <= '0;
         err_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         sum_q   <= sum_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign beat      = beat_q;
   assign sum       = sum_q;
   assign err_count = err_q;
   assign done      = done_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_sig_check.sv
// Scoreboard bench for sig_check: two instances (OFFSET=2 and OFFSET=all-ones)
// driven by an LFSR transmitter, checked against a beat-level reference model.
module tb_sig_check;

   localparam logic [63:0] SEED   = 64'h5aef0c8d_d70a4497;
   localparam logic [63:0] GOLD   = 64'hf9b3a500_0165ed38;
   localparam logic [31:0] OFF0   = 32'd2;
   localparam logic [31:0] OFF1   = 32'hffffffff;
   localparam int          WARM   = 10;
   localparam int          LASTB  = 99;

   typedef struct {
      int          u;
      logic [31:0] beat;
      logic [15:0] err;
      logic [63:0] sum;
      logic        done;
      logic        pass;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset_l;
   logic        v [2];
   logic [31:0] d [2];
   logic [31:0] beat_w [2];
   logic [63:0] sum_w [2];
   logic [15:0] err_w [2];
   logic        done_w [2];
   logic        pass_w [2];

   always #5 clk = ~clk;

   sig_check #(.OFFSET(OFF0)) u_dut0 (
      .clk(clk), .reset_l(reset_l), .in_valid(v[0]), .in_data(d[0]),
      .beat(beat_w[0]), .sum(sum_w[0]), .err_count(err_w[0]),
      .done(done_w[0]), .pass(pass_w[0])
   );

   sig_check #(.OFFSET(OFF1)) u_dut1 (
      .clk(clk), .reset_l(reset_l), .in_valid(v[1]), .in_data(d[1]),
      .beat(beat_w[1]), .sum(sum_w[1]), .err_count(err_w[1]),
      .done(done_w[1]), .pass(pass_w[1])
   );

   // Scoreboard queues: per-beat expectations and one-shot snapshots.
   rec_t q0 [$];
   rec_t q1 [$];
   rec_t snap_q [$];
   bit   finish_req = 1'b0;

   // Reference model state (per instance) and transmitter state.
   logic [63:0] m_crc [2];
   logic [63:0] m_sum [2];
   logic [15:0] m_err [2];
   int          m_k [2];
   bit          m_done [2];
   bit          m_pass [2];
   logic [31:0] off [2];
   logic [63:0] tx_crc [2];

   function automatic logic [63:0] step(input logic [63:0] x);
      return {x[62:0], x[63] ^ x[2] ^ x[0]};
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_crc[u]  = SEED;
         m_sum[u]  = '0;
         m_err[u]  = '0;
         m_k[u]    = 0;
         m_done[u] = 1'b0;
         m_pass[u] = 1'b0;
         tx_crc[u] = SEED;
      end
   endtask

   function automatic rec_t model_rec(input int u);
      rec_t r;
      r.u    = u;
      r.beat = 32'(m_k[u]);
      r.err  = m_err[u];
      r.sum  = m_sum[u];
      r.done = m_done[u];
      r.pass = m_pass[u];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat; the model decides whether it is accepted.
   task automatic send(input int u, input logic [31:0] data);
      logic [31:0] e;
      v[u] = 1'b1;
      d[u] = data;
      if (!m_done[u]) begin
         e = m_crc[u][31:0] + off[u];
         if (data != e && m_err[u] != 16'hffff) m_err[u] = m_err[u] + 16'd1;
         if (m_k[u] >= WARM && m_k[u] < LASTB)
            m_sum[u] = {32'h0, data} ^ step(m_sum[u]);
         m_crc[u] = step(m_crc[u]);
         if (m_k[u] == LASTB) begin
            m_done[u] = 1'b1;
            m_pass[u] = (m_sum[u] == GOLD) && (m_err[u] == 16'd0);
         end
         m_k[u] = m_k[u] + 1;
         if (u == 0) q0.push_back(model_rec(u));
         else        q1.push_back(model_rec(u));
      end
      tick();
      v[u] = 1'b0;
   endtask

   // Transmit n beats of the LFSR stream; optionally flip bit 0 of one beat.
   task automatic stream(input int u, input int n, input int flip_k, input bit gaps);
      logic [31:0] data;
      for (int k = 0; k < n; k++) begin
         if (gaps) repeat ($urandom_range(0, 3)) tick();
         data = tx_crc[u][31:0] + off[u];
         if (k == flip_k) data = data ^ 32'h1;
         tx_crc[u] = step(tx_crc[u]);
         send(u, data);
      end
   endtask

   // Synchronous reset pulse; optionally hold in_valid high on instance 0 during it.
   task automatic do_reset(input bit valid_during);
      v[0]    = valid_during;
      d[0]    = $urandom;
      v[1]    = 1'b0;
      reset_l = 1'b0;
      tick();
      reset_l = 1'b1;
      v[0]    = 1'b0;
      model_reset();
      snap_q.push_back(model_rec(0));
      snap_q.push_back(model_rec(1));
   endtask

   task automatic post_done_beats(input int u);
      repeat (3) send(u, $urandom);
      snap_q.push_back(model_rec(u));
   endtask

   // Stimulus.
   initial begin
      reset_l = 1'b0;
      v[0] = 1'b0; v[1] = 1'b0;
      d[0] = '0;   d[1] = '0;
      off[0] = OFF0;
      off[1] = OFF1;
      model_reset();
      repeat (2) tick();
      do_reset(1'b0);
      tick();

      stream(0, 100, -1, 1'b0);        // clean contiguous
      tick();
      post_done_beats(0);
      tick();

      do_reset(1'b0);
      stream(0, 100, 50, 1'b0);        // accumulate-phase corruption
      tick();

      do_reset(1'b0);
      stream(0, 100, 3, 1'b0);         // warmup corruption
      tick();

      do_reset(1'b0);
      stream(0, 100, -1, 1'b1);        // random gaps
      tick();

      do_reset(1'b0);
      stream(0, 40, -1, 1'b0);
      do_reset(1'b1);                  // mid-stream reset, valid held high
      stream(0, 100, -1, 1'b0);
      tick();

      do_reset(1'b0);
      stream(1, 100, -1, 1'b0);        // offset wrap instance
      tick();
      post_done_beats(1);
      repeat (2) tick();

      finish_req = 1'b1;
   end

   // Watchdog.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: finish not reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   int   tests = 0;
   int   fails = 0;
   logic [31:0] prev [2];

   task automatic chk(input string nm, input int u, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %h required %h at %0t", nm, u, act, exp, $time);
      end
   endtask

   task automatic chk_rec(input string tag, input rec_t r);
      chk({tag, "_beat"}, r.u, 64'(beat_w[r.u]), 64'(r.beat));
      chk({tag, "_err"},  r.u, 64'(err_w[r.u]),  64'(r.err));
      chk({tag, "_sum"},  r.u, sum_w[r.u],       r.sum);
      chk({tag, "_done"}, r.u, 64'(done_w[r.u]), 64'(r.done));
      if (r.done) chk({tag, "_pass"}, r.u, 64'(pass_w[r.u]), 64'(r.pass));
   endtask

   // Monitor: pop an expectation whenever a DUT accepts a beat, plus snapshots.
   always @(negedge clk) begin
      rec_t r;
      bit   have;
      for (int u = 0; u < 2; u++) begin
         if (beat_w[u] !== prev[u]) begin
            if (beat_w[u] != 32'd0) begin
               have = 1'b0;
               if (u == 0 && q0.size() > 0) begin r = q0.pop_front(); have = 1'b1; end
               if (u == 1 && q1.size() > 0) begin r = q1.pop_front(); have = 1'b1; end
               if (have) chk_rec("beat", r);
               else begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_beat dut%0d: got beat %0d required no change", u, beat_w[u]);
               end
            end
            prev[u] = beat_w[u];
         end
      end
      while (snap_q.size() > 0) begin
         r = snap_q.pop_front();
         chk_rec("snap", r);
      end
      if (finish_req) begin
         chk("q0_drained", 0, 64'(q0.size()), 64'd0);
         chk("q1_drained", 1, 64'(q1.size()), 64'd0);
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   end

endmodule
